// File: rtl/ixc_assign_arb.sv
// Round-robin arbiter sharing one W-bit assign path between NREQ requesters.
// Latency: one register stage; REQ at edge k gives L/L_VLD/GNT in cycle k+1.
// Backpressure: while L_VLD && !L_RDY, L/L_VLD/PTR hold and no capture occurs.
//
// Ports:
//   CLK, RSTN        clock (rising edge), async active-low reset
//   REQ[NREQ]        per-requester request; pairs with slice R[i*W +: W]
//   R[NREQ*W]        requester data
//   GNT[NREQ]        one-hot capture acknowledge, one-cycle pulse
//   L[W], L_VLD      registered shared value and its valid flag
//   L_RDY            downstream accepts L this cycle
//   PTR[PW]          round-robin priority pointer (visibility)
module ixc_assign_arb #(
  parameter int NREQ = 4,
  parameter int W    = 2,
  localparam int PW  = $clog2(NREQ)
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic [NREQ-1:0]   REQ,
  input  logic [NREQ*W-1:0] R,
  output logic [NREQ-1:0]   GNT,
  output logic [W-1:0]      L,
  output logic              L_VLD,
  input  logic              L_RDY,
  output logic [PW-1:0]     PTR
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state;
  logic            free;
  logic [NREQ-1:0] elig;
  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   ptr_nxt;
  logic [NREQ-1:0] win_onehot;
  logic [W-1:0]    win_dat;
  int              idx;

  assign L_VLD = (state == FULL);

  // Slot can take a new value if empty or if the held value leaves this cycle.
  assign free = (state == EMPTY) || L_RDY;

  // A requester acknowledged last cycle may still show its old REQ; masking
  // it prevents capturing the same request twice.
  assign elig = REQ & ~GNT;

  // Scan from PTR upward with wrap; first eligible requester wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(PTR) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_found && elig[idx]) begin
        win_found = 1'b1;
        win_idx   = PW'(idx);
      end
    end
  end

  always_comb begin
    if (win_idx == PW'(NREQ - 1)) ptr_nxt = '0;
    else                          ptr_nxt = win_idx + PW'(1);
  end

  assign win_onehot = NREQ'(1) << win_idx;
  assign win_dat    = R[int'(win_idx)*W +: W];

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= EMPTY;
      L     <= '0;
      GNT   <= '0;
      PTR   <= '0;
    end else begin
      GNT <= '0;
      if (free && win_found) begin
        // Capture: covers both EMPTY->FULL and back-to-back FULL->FULL.
        state <= FULL;
        L     <= win_dat;
        GNT   <= win_onehot;
        PTR   <= ptr_nxt;
      end else if (free) begin
        // Held value (if any) transferred with nothing to replace it.
        state <= EMPTY;
      end
      // Not free: L, state and PTR hold.
    end
  end

endmodule

// File: tb/tb_ixc_assign_arb.sv
module tb_ixc_assign_arb;
  localparam int NREQ = 4;
  localparam int W    = 2;
  localparam int PW   = 2;

  logic              CLK;
  logic              RSTN;
  logic [NREQ-1:0]   REQ;
  logic [NREQ*W-1:0] R;
  logic [NREQ-1:0]   GNT;
  logic [W-1:0]      L;
  logic              L_VLD;
  logic              L_RDY;
  logic [PW-1:0]     PTR;

  ixc_assign_arb #(.NREQ(NREQ), .W(W)) dut (
    .CLK(CLK), .RSTN(RSTN), .REQ(REQ), .R(R), .GNT(GNT),
    .L(L), .L_VLD(L_VLD), .L_RDY(L_RDY), .PTR(PTR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int gnt;
    int l;
    int ptr;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: what the outputs should be after the last edge.
  int m_vld;
  int m_ptr;
  int m_gnt;
  int m_l;

  int n_checks;
  int n_fail;
  bit done;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Drive one cycle of inputs and predict the outcome of the following edge.
  task automatic drive(input int req, input int r, input int rdy);
    int free, elig, w;
    exp_t e;
    @(negedge CLK);
    REQ   = NREQ'(req);
    R     = (NREQ*W)'(r);
    L_RDY = rdy[0];
    free  = (m_vld == 0) || (rdy != 0);
    elig  = req & ~m_gnt & ((1 << NREQ) - 1);
    w     = -1;
    if (free != 0 && elig != 0) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (w < 0 && ((elig >> i) & 1) != 0) w = i;
      end
      m_l   = (r >> (w * W)) & ((1 << W) - 1);
      m_vld = 1;
      m_gnt = 1 << w;
      m_ptr = (w + 1) % NREQ;
      e.gnt = m_gnt;
      e.l   = m_l;
      e.ptr = m_ptr;
      exp_q.push_back(e);
    end else begin
      if (free != 0) m_vld = 0;
      m_gnt = 0;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: every grant must match the oldest predicted capture.
  initial begin
    exp_t e;
    while (!done) begin
      @(posedge CLK);
      #1;
      if (done) break;
      if (GNT != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_gnt", int'(GNT), 0);
        end else begin
          e = exp_q.pop_front();
          chk("mon_gnt", int'(GNT), e.gnt);
          chk("mon_l",   int'(L),   e.l);
          chk("mon_ptr", int'(PTR), e.ptr);
        end
      end
      chk("mon_vld",   int'(L_VLD), m_vld);
      chk("mon_ptr_c", int'(PTR),   m_ptr);
      if (m_vld != 0) chk("mon_l_c", int'(L), m_l);
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    done     = 1'b0;
    m_vld = 0; m_ptr = 0; m_gnt = 0; m_l = 0;
    RSTN  = 1'b0;
    REQ   = '0;
    R     = '0;
    L_RDY = 1'b0;
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;

    // Rotation with all requesting, slice i carries value i.
    for (int k = 0; k < 5; k++) begin
      drive(4'hF, 8'b11100100, 1);
      tick();
      chk("rot_gnt", int'(GNT), 1 << (k % 4));
      chk("rot_l",   int'(L),   k % 4);
      chk("rot_ptr", int'(PTR), (k + 1) % 4);
    end
    drive(0, 0, 1);

    // Reset while FULL holding 2'b11.
    drive(4'b0001, 8'b00000011, 0);
    tick();
    chk("pre_rst_l", int'(L), 3);
    @(negedge CLK);
    RSTN  = 1'b0;
    REQ   = '0;
    L_RDY = 1'b0;
    m_vld = 0; m_ptr = 0; m_gnt = 0; m_l = 0;
    exp_q.delete();
    #1;
    chk("rst_l",   int'(L),     0);
    chk("rst_vld", int'(L_VLD), 0);
    chk("rst_gnt", int'(GNT),   0);
    chk("rst_ptr", int'(PTR),   0);
    @(negedge CLK);
    RSTN = 1'b1;
    drive(0, 0, 1);
    tick();
    chk("post_rst_gnt", int'(GNT), 0);

    // Single requester, REQ held one extra cycle.
    drive(4'b0100, 8'b00100000, 1);
    tick();
    chk("single_l",   int'(L),     2);
    chk("single_vld", int'(L_VLD), 1);
    chk("single_gnt", int'(GNT),   4);
    chk("single_ptr", int'(PTR),   3);
    drive(4'b0100, 8'b00100000, 1);
    tick();
    chk("single_nognt", int'(GNT),   0);
    chk("single_drop",  int'(L_VLD), 0);
    drive(0, 0, 1);

    // Backpressure: hold L=01 for 5 cycles with requester 1 waiting.
    drive(4'b0001, 8'b00000001, 0);
    tick();
    chk("bp_l0",   int'(L),   1);
    chk("bp_ptr0", int'(PTR), 1);
    for (int k = 0; k < 5; k++) begin
      drive(4'b0010, 8'b00001000, 0);
      tick();
      chk("bp_gnt", int'(GNT),   0);
      chk("bp_l",   int'(L),     1);
      chk("bp_vld", int'(L_VLD), 1);
      chk("bp_ptr", int'(PTR),   1);
    end
    drive(4'b0010, 8'b00001000, 1);
    tick();
    chk("bp_rel_gnt", int'(GNT), 2);
    chk("bp_rel_l",   int'(L),   2);
    chk("bp_rel_ptr", int'(PTR), 2);

    // Wrap priority from PTR=3.
    drive(4'b0100, 8'b00110000, 1);
    tick();
    chk("wrap_ptr3", int'(PTR), 3);
    drive(4'b0011, 8'b00000110, 1);
    tick();
    chk("wrap_gnt0", int'(GNT), 1);
    chk("wrap_l0",   int'(L),   2);
    chk("wrap_ptr1", int'(PTR), 1);
    drive(4'b0011, 8'b00000110, 1);
    tick();
    chk("wrap_gnt1", int'(GNT), 2);
    chk("wrap_l1",   int'(L),   1);
    chk("wrap_ptr2", int'(PTR), 2);

    // Withdrawal while stalled, then drain to EMPTY.
    drive(0, 0, 0);
    drive(4'b0001, 8'b00000011, 0);
    tick();
    chk("wd_gnt", int'(GNT), 0);
    drive(0, 0, 0);
    drive(0, 0, 1);
    tick();
    chk("wd_vld", int'(L_VLD), 0);
    chk("wd_gnt2", int'(GNT),  0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      drive(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
            ($urandom_range(0, 9) < 7) ? 1 : 0);
    end

    repeat (3) drive(0, 0, 1);
    tick();
    chk("queue_empty", exp_q.size(), 0);

    done = 1'b1;
    @(posedge CLK);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
